// File: rtl/systolic_host_sequencer.sv
// rtl/systolic_host_sequencer.sv - streams buffered host operands into the systolic driver, flushes, and collects results
// Optional macro SYS_HOST_PERF_EN adds perf_cycles_o (cycles from accepted start through done).
module systolic_host_sequencer #(
    parameter int width_p        = 32,
    parameter int array_width_p  = 8,
    parameter int array_height_p = 8,
    parameter int fifo_depth_p   = 16,
    parameter int max_steps_p    = 8
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          start_i,
    input  logic [$clog2(max_steps_p+1)-1:0]              steps_i,
    input  logic                                          op_valid_i,
    output logic                                          op_ready_o,
    input  logic [width_p-1:0]                            op_data_i,
    output logic                                          arr_valid_o,
    input  logic                                          arr_ready_i,
    output logic [width_p-1:0]                            arr_data_o,
    output logic                                          arr_flush_o,
    input  logic                                          arr_idle_i,
    input  logic                                          arr_valid_i,
    output logic                                          arr_yumi_o,
    input  logic [width_p-1:0]                            arr_data_i,
    input  logic [$clog2(array_width_p*array_height_p)-1:0] res_addr_i,
    output logic [width_p-1:0]                            res_data_o,
    output logic                                          busy_o,
    output logic                                          done_o,
`ifdef SYS_HOST_PERF_EN
    output logic [31:0]                                   perf_cycles_o,
`endif
    output logic                                          err_o
);

    localparam int vec_lp    = array_width_p + array_height_p;
    localparam int res_n_lp  = array_width_p * array_height_p;
    localparam int cnt_w_lp  = $clog2(max_steps_p * vec_lp + 1);
    localparam int addr_w_lp = $clog2(res_n_lp);
    localparam int ptr_w_lp  = $clog2(fifo_depth_p);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT, S_FLUSH, S_COLLECT, S_DONE
    } state_t;

    state_t state, state_n;

    logic [width_p-1:0]  fifo_mem [fifo_depth_p];
    logic [ptr_w_lp:0]   wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, push, pop;

    logic [width_p-1:0]  res_mem [res_n_lp];
    logic [addr_w_lp-1:0] res_idx;
    logic [cnt_w_lp-1:0] word_cnt, total_q;
    logic                steps_ok, start_ok, last_word, last_res;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ptr_w_lp] != rd_ptr[ptr_w_lp]) &&
                        (wr_ptr[ptr_w_lp-1:0] == rd_ptr[ptr_w_lp-1:0]);
    assign push       = op_valid_i && !fifo_full;
    assign pop        = arr_valid_o && arr_ready_i;

    assign steps_ok  = (steps_i != '0) && (int'(steps_i) <= max_steps_p);
    assign start_ok  = (state == S_IDLE) && start_i && steps_ok;
    assign last_word = (word_cnt == total_q - 1'b1);
    assign last_res  = (res_idx == addr_w_lp'(res_n_lp - 1));

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[ptr_w_lp-1:0]] <= op_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (start_ok) state_n = S_SEND;
            S_SEND:    if (pop && last_word) state_n = S_WAIT;
            S_WAIT:    if (arr_idle_i) state_n = S_FLUSH;
            S_FLUSH:   state_n = S_COLLECT;
            S_COLLECT: if (arr_valid_i && last_res) state_n = S_DONE;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready_o  = !fifo_full;
        arr_valid_o = (state == S_SEND) && !fifo_empty;
        arr_data_o  = fifo_empty ? '0 : fifo_mem[rd_ptr[ptr_w_lp-1:0]];
        arr_flush_o = (state == S_FLUSH);
        arr_yumi_o  = (state == S_COLLECT) && arr_valid_i;
        busy_o      = (state != S_IDLE);
        done_o      = (state == S_DONE);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            word_cnt <= '0;
            total_q  <= '0;
            res_idx  <= '0;
            err_o    <= 1'b0;
        end else begin
            if (state == S_IDLE && start_i) begin
                if (steps_ok) begin
                    err_o    <= 1'b0;
                    word_cnt <= '0;
                    res_idx  <= '0;
                    total_q  <= cnt_w_lp'(int'(steps_i) * vec_lp);
                end else begin
                    err_o <= 1'b1;
                end
            end
            if (pop) word_cnt <= word_cnt + 1'b1;
            if (arr_yumi_o) res_idx <= last_res ? '0 : res_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arr_yumi_o) begin
            res_mem[res_idx] <= arr_data_i;
        end
    end

    // Same-cycle write and read of one index returns the previous contents.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            res_data_o <= '0;
        end else begin
            res_data_o <= res_mem[res_addr_i];
        end
    end

`ifdef SYS_HOST_PERF_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            perf_cycles_o <= '0;
        end else if (start_ok) begin
            perf_cycles_o <= 32'd1;
        end else if (state != S_IDLE && perf_cycles_o != 32'hFFFF_FFFF) begin
            perf_cycles_o <= perf_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_host_sequencer.sv
// tb/tb_systolic_host_sequencer.sv - scoreboard bench for systolic_host_sequencer on a 2x2 array
module tb_systolic_host_sequencer;

    localparam int FD = 8;

    logic        clk_i, reset_i, start_i;
    logic [3:0]  steps_i;
    logic        op_valid_i, op_ready_o;
    logic [31:0] op_data_i;
    logic        arr_valid_o, arr_ready_i, arr_flush_o, arr_idle_i;
    logic [31:0] arr_data_o, arr_data_i;
    logic        arr_valid_i, arr_yumi_o;
    logic [1:0]  res_addr_i;
    logic [31:0] res_data_o;
    logic        busy_o, done_o, err_o;
`ifdef SYS_HOST_PERF_EN
    logic [31:0] perf_cycles_o;
`endif

    int checks, errors;
    int hs_cnt, flush_cnt, done_cnt;
    logic        stalled;
    logic [31:0] stall_data;
    logic [31:0] op_q[$];
    logic [31:0] res_q[$];

    systolic_host_sequencer #(
        .width_p(32), .array_width_p(2), .array_height_p(2),
        .fifo_depth_p(FD), .max_steps_p(8)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .steps_i(steps_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_data_i(op_data_i),
        .arr_valid_o(arr_valid_o), .arr_ready_i(arr_ready_i), .arr_data_o(arr_data_o),
        .arr_flush_o(arr_flush_o), .arr_idle_i(arr_idle_i),
        .arr_valid_i(arr_valid_i), .arr_yumi_o(arr_yumi_o), .arr_data_i(arr_data_i),
        .res_addr_i(res_addr_i), .res_data_o(res_data_o),
        .busy_o(busy_o), .done_o(done_o),
`ifdef SYS_HOST_PERF_EN
        .perf_cycles_o(perf_cycles_o),
`endif
        .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic step();
        logic [31:0] exp;
        @(negedge clk_i);
        if (reset_i) begin
            if (arr_valid_o && arr_ready_i) begin
                hs_cnt++;
                checks++;
                if (op_q.size() == 0) begin
                    errors++;
                    $display("FAIL arr_word unexpected got %0d want none", arr_data_o);
                end else begin
                    exp = op_q.pop_front();
                    if (arr_data_o !== exp) begin
                        errors++;
                        $display("FAIL arr_word got %0d want %0d", arr_data_o, exp);
                    end
                end
            end
            if (stalled) begin
                checks++;
                if (arr_valid_o !== 1'b1 || arr_data_o !== stall_data) begin
                    errors++;
                    $display("FAIL stall_hold got v=%0b d=%0d want v=1 d=%0d", arr_valid_o, arr_data_o, stall_data);
                end
            end
            stalled    = arr_valid_o && !arr_ready_i;
            stall_data = arr_data_o;
            if (op_valid_i && op_ready_o) op_q.push_back(op_data_i);
            if (arr_flush_o) flush_cnt++;
            if (done_o) done_cnt++;
        end else begin
            stalled = 1'b0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input int s);
        steps_i = 4'(s);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic push_words(input int n, input int base);
        int acc;
        int guard;
        acc = 0;
        guard = 0;
        op_valid_i = 1'b1;
        while (acc < n && guard < 100) begin
            op_data_i = 32'(base + acc);
            if (op_ready_o) acc++;
            step();
            guard++;
        end
        op_valid_i = 1'b0;
    endtask

    task automatic wait_flush();
        int f0;
        int g;
        f0 = flush_cnt;
        g = 0;
        while (flush_cnt == f0 && g < 50) begin
            step();
            g++;
        end
        checks++;
        if (flush_cnt == f0) begin
            errors++;
            $display("FAIL flush_timeout got %0d flushes want %0d", flush_cnt, f0 + 1);
        end
    endtask

    task automatic wait_done();
        int d0;
        int g;
        d0 = done_cnt;
        g = 0;
        while (done_cnt == d0 && g < 50) begin
            step();
            g++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL done_timeout got %0d dones want %0d", done_cnt, d0 + 1);
        end
    endtask

    task automatic send_results(input int base, input int gap_at);
        for (int k = 0; k < 4; k++) begin
            if (k == gap_at) begin
                arr_valid_i = 1'b0;
                #1;
                checks++;
                if (arr_yumi_o !== 1'b0) begin
                    errors++;
                    $display("FAIL yumi_gap got %0b want 0", arr_yumi_o);
                end
                step();
            end
            arr_valid_i = 1'b1;
            arr_data_i  = 32'(base * (k + 1));
            res_q.push_back(arr_data_i);
            #1;
            checks++;
            if (arr_yumi_o !== 1'b1) begin
                errors++;
                $display("FAIL yumi_beat got %0b want 1", arr_yumi_o);
            end
            step();
        end
        arr_valid_i = 1'b0;
    endtask

    task automatic check_results();
        logic [31:0] exp;
        for (int a = 0; a < 4; a++) begin
            res_addr_i = 2'(a);
            step();
            exp = (res_q.size() != 0) ? res_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (res_data_o !== exp) begin
                errors++;
                $display("FAIL res_read[%0d] got %0d want %0d", a, res_data_o, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        #2;
        reset_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, arr_valid_o, arr_flush_o, arr_yumi_o} !== 6'b0 || op_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got busy=%0b done=%0b err=%0b av=%0b fl=%0b yu=%0b rdy=%0b want 0s and rdy=1",
                     busy_o, done_o, err_o, arr_valid_o, arr_flush_o, arr_yumi_o, op_ready_o);
        end
        step();
        checks++;
        if (res_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_res_data got %0d want 0", res_data_o);
        end
        reset_i = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int h0, f0, d0;
        h0 = hs_cnt; f0 = flush_cnt; d0 = done_cnt;
        arr_idle_i = 1'b0;
        start_job(1);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %0b want 1", busy_o);
        end
        push_words(4, 1);
        repeat (3) step();
        checks++;
        if (flush_cnt != f0 || hs_cnt - h0 != 4) begin
            errors++;
            $display("FAIL basic_wait got flush=%0d hs=%0d want flush=0 hs=4", flush_cnt - f0, hs_cnt - h0);
        end
        arr_idle_i = 1'b1;
        wait_flush();
        send_results(100, 99);
        wait_done();
        repeat (2) step();
        checks++;
        if (hs_cnt - h0 != 4 || flush_cnt - f0 != 1 || done_cnt - d0 != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_counts got hs=%0d flush=%0d done=%0d busy=%0b want 4 1 1 0",
                     hs_cnt - h0, flush_cnt - f0, done_cnt - d0, busy_o);
        end
        check_results();
    endtask

    task automatic test_stall();
        int h0;
        h0 = hs_cnt;
        start_job(1);
        push_words(2, 20);
        arr_ready_i = 1'b0;
        push_words(2, 22);
        repeat (3) step();
        arr_ready_i = 1'b1;
        wait_flush();
        send_results(7, 2);
        wait_done();
        checks++;
        if (hs_cnt - h0 != 4 || op_q.size() != 0) begin
            errors++;
            $display("FAIL stall_words got hs=%0d left=%0d want hs=4 left=0", hs_cnt - h0, op_q.size());
        end
        check_results();
    endtask

    task automatic test_results();
        start_job(1);
        push_words(4, 40);
        wait_flush();
        send_results(10, 1);
        wait_done();
        check_results();
    endtask

    task automatic test_err();
        start_job(0);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL err_zero got err=%0b busy=%0b want 1 0", err_o, busy_o);
        end
        start_job(9);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL err_over got err=%0b busy=%0b want 1 0", err_o, busy_o);
        end
        start_job(1);
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL err_clear got err=%0b busy=%0b want 0 1", err_o, busy_o);
        end
        push_words(4, 60);
        wait_flush();
        send_results(3, 99);
        wait_done();
        check_results();
    endtask

    task automatic test_fifo_full();
        int acc, h0;
        acc = 0;
        h0 = hs_cnt;
        op_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            op_data_i = 32'(200 + i);
            checks++;
            if (op_ready_o !== (acc < FD)) begin
                errors++;
                $display("FAIL fifo_ready[%0d] got %0b want %0b", i, op_ready_o, (acc < FD));
            end
            if (op_ready_o) acc++;
            step();
        end
        op_valid_i = 1'b0;
        checks++;
        if (acc != FD) begin
            errors++;
            $display("FAIL fifo_accepted got %0d want %0d", acc, FD);
        end
        start_job(2);
        wait_flush();
        checks++;
        if (hs_cnt - h0 != FD || op_q.size() != 0) begin
            errors++;
            $display("FAIL fifo_drain got hs=%0d left=%0d want hs=%0d left=0", hs_cnt - h0, op_q.size(), FD);
        end
        send_results(5, 3);
        wait_done();
        check_results();
    endtask

    task automatic test_reset_mid_collect();
        int d0;
        d0 = done_cnt;
        start_job(1);
        push_words(4, 80);
        wait_flush();
        push_words(2, 90);
        arr_valid_i = 1'b1;
        arr_data_i  = 32'd5;
        step();
        step();
        reset_i = 1'b0;
        arr_valid_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || op_ready_o !== 1'b1 || arr_valid_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset got busy=%0b rdy=%0b av=%0b done=%0b want 0 1 0 0",
                     busy_o, op_ready_o, arr_valid_o, done_o);
        end
        op_q.delete();
        res_q.delete();
        repeat (2) step();
        reset_i = 1'b1;
        step();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL midreset_done got %0d want %0d", done_cnt - d0, 0);
        end
        start_job(1);
        push_words(4, 70);
        wait_flush();
        send_results(11, 3);
        wait_done();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL midreset_rerun got %0d dones want 1", done_cnt - d0);
        end
        check_results();
    endtask

    initial begin
        checks = 0; errors = 0;
        hs_cnt = 0; flush_cnt = 0; done_cnt = 0;
        stalled = 1'b0; stall_data = '0;
        reset_i = 1'b1; start_i = 1'b0; steps_i = '0;
        op_valid_i = 1'b0; op_data_i = '0;
        arr_ready_i = 1'b1; arr_idle_i = 1'b1;
        arr_valid_i = 1'b0; arr_data_i = '0; res_addr_i = '0;

        test_reset();
        test_basic();
        test_stall();
        test_results();
        test_err();
        test_fifo_full();
        test_reset_mid_collect();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
